median5_filter: RTL and testbench
=================================

Name: median5_filter

Overview:
- Five-tap median filter for impulse ("salt-and-pepper") noise removal on an 8-bit sample stream.
- Upstream logic presents the current sample and the four preceding samples in parallel.
- The block registers the median (3rd-smallest) of the five values on each clock edge.
- Sits directly after the sample delay line; output feeds downstream processing.

Parameters:
- DATA_W, 8, width of each sample and of the output; unsigned.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- distortedInputm4  input  DATA_W  sample n-4.
- distortedInputm3  input  DATA_W  sample n-3.
- distortedInputm2  input  DATA_W  sample n-2.
- distortedInputm1  input  DATA_W  sample n-1.
- distortedInput  input  DATA_W  sample n (newest).
- filteredOutput  output  DATA_W  registered median of the five inputs.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low forces filteredOutput to 0 immediately, independent of clk.
  - filteredOutput holds 0 while rst_n stays low.
  - Deassertion is sampled at clk; the first update happens on the first rising edge with rst_n high.
- Function: filteredOutput = median of the five inputs, i.e. the value at index 2 (0-based) after an ascending sort.
- Comparison is unsigned, full DATA_W bits.
- Tap order does not affect the result; the result is permutation-invariant.
- Duplicates: the median may equal a duplicated value, e.g. {9,9,1,200,9} -> 9.
- The output is always one of the input values; there is no averaging and no rounding.
- Latency: exactly 1 clock.
  - Inputs stable before rising edge k appear on filteredOutput after edge k.
  - The block accepts a new input set every cycle; no handshake, no stall.
- Median network: combinational 7-comparator network.
  - Stages: sort (a,b); sort (d,e); sort (a,d) -> e.g. discard minimum; sort (b,e) -> discard maximum; then median of the remaining three with c.
  - Any network proven to return the 3rd order statistic is acceptable; it must be verified exhaustively on random vectors against a reference sort.
- No internal state other than the output register.
- Reset asserted mid-stream clears the output at once; the output resumes one cycle after release with the current inputs' median.
- X on any input may propagate; no X-masking is required.

Decomposition:
- Shared package median_pkg:
  - DATA_W default constant (8).
  - Typedef sample_t = logic [DATA_W-1:0].
- Sub-module cmp_swap:
  - Inputs a, b (sample_t); outputs lo = min, hi = max; unsigned; purely combinational.
  - Instantiated 7 times in the median network.
- Top median5_filter: network wiring plus the output register with asynchronous reset.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs and toggle clk -> filteredOutput=0 throughout; assert rst_n mid-stream -> output drops to 0 without waiting for clk.
- Sliding ramp: for i=5..19 apply m4=i-2, m3=i, m2=i-1, m1=i+2, n=i+1, one set per 100 ns clock period -> filteredOutput=i one cycle later (5,6,...,19), updating every cycle.
- Duplicates and equality:
  - {9,9,1,200,9} -> 9.
  - All inputs 0xAA -> 0xAA.
  - {0,255,255,0,128} -> 128.
- Unsigned ordering: {0x80,0x7F,0xFF,0x00,0x81} -> 0x80, not a signed result.
- Impulse rejection: a stream of 50 with a single 255 spike on any one tap -> 50; the same with a 0 dropout -> 50.
- Random regression: 10,000 random 5-tuples including all 120 permutations of {1,2,3,4,5} -> output equals the sorted[2] reference with 1-cycle latency; permutations all yield 3.

Source files
------------

// File: rtl/median_pkg.sv
// Shared sample width and sample type for the five-tap median filter.
package median_pkg;
    localparam int DATA_W = 8;
    typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/median5_filter_cmp_swap.sv
// Unsigned compare-and-swap cell: the smaller value goes to lo, the larger to hi.
module cmp_swap
    import median_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);
    always_comb begin
        lo = a;
        hi = b;
        if (a > b) begin
            lo = b;
            hi = a;
        end
    end
endmodule

// File: rtl/median5_filter.sv
// Five-tap median filter: a 7-comparator network feeding one output register
// that is cleared asynchronously by rst_n.
module median5_filter #(
    parameter int DATA_W = median_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] distortedInputm4,
    input  logic [DATA_W-1:0] distortedInputm3,
    input  logic [DATA_W-1:0] distortedInputm2,
    input  logic [DATA_W-1:0] distortedInputm1,
    input  logic [DATA_W-1:0] distortedInput,
    output logic [DATA_W-1:0] filteredOutput
);
    logic [DATA_W-1:0] ab_lo, ab_hi, de_lo, de_hi;
    logic [DATA_W-1:0] disc_min, lo4, hi4, disc_max;
    logic [DATA_W-1:0] p_lo, p_hi, t_lo, t_hi, fin_lo, med;
    logic [DATA_W-1:0] filtered_q, filtered_d;

    // a=m4, b=m3, c=m2, d=m1, e=n
    cmp_swap #(.W(DATA_W)) u_ab (.a(distortedInputm4), .b(distortedInputm3), .lo(ab_lo), .hi(ab_hi));
    cmp_swap #(.W(DATA_W)) u_de (.a(distortedInputm1), .b(distortedInput),   .lo(de_lo), .hi(de_hi));

    // The min and max of {a,b,d,e} cannot be the median of five; drop them.
    cmp_swap #(.W(DATA_W)) u_lo (.a(ab_lo), .b(de_lo), .lo(disc_min), .hi(lo4));
    cmp_swap #(.W(DATA_W)) u_hi (.a(ab_hi), .b(de_hi), .lo(hi4), .hi(disc_max));

    // Median of {lo4, hi4, c} = max(min pair, min(max pair, c)).
    cmp_swap #(.W(DATA_W)) u_pr (.a(lo4), .b(hi4), .lo(p_lo), .hi(p_hi));
    cmp_swap #(.W(DATA_W)) u_tc (.a(p_hi), .b(distortedInputm2), .lo(t_lo), .hi(t_hi));
    cmp_swap #(.W(DATA_W)) u_md (.a(p_lo), .b(t_lo), .lo(fin_lo), .hi(med));

    always_comb begin
        filtered_d = med;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filtered_q <= '0;
        end else begin
            filtered_q <= filtered_d;
        end
    end

    assign filteredOutput = filtered_q;

    // Every discarded value must bracket the chosen median.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (disc_min <= med && fin_lo <= med && med <= t_hi && med <= disc_max);
        end
    end
endmodule

// File: tb/tb_median5_filter.sv
// Directed and random checks of the five-tap median filter against hand values and a sort reference.
module tb_median5_filter;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_m4, in_m3, in_m2, in_m1, in_n;
    logic [7:0] filtered_output;

    int errors = 0;
    int checks = 0;

    median5_filter #(.DATA_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .distortedInputm4 (in_m4),
        .distortedInputm3 (in_m3),
        .distortedInputm2 (in_m2),
        .distortedInputm1 (in_m1),
        .distortedInput   (in_n),
        .filteredOutput   (filtered_output)
    );

    // clock / reset
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic drive(input logic [7:0] v4, v3, v2, v1, v0);
        in_m4 = v4;
        in_m3 = v3;
        in_m2 = v2;
        in_m1 = v1;
        in_n  = v0;
    endtask

    function automatic logic [7:0] ref_median(input logic [7:0] v4, v3, v2, v1, v0);
        logic [7:0] s [5];
        logic [7:0] t;
        s[0] = v4; s[1] = v3; s[2] = v2; s[3] = v1; s[4] = v0;
        for (int i = 1; i < 5; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        return s[2];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'd200, 8'd17, 8'd99, 8'd3, 8'd150);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (filtered_output !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %0d expected 0", k, filtered_output);
            end
        end
        // release at a falling edge; first update on the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (filtered_output !== 8'd0) begin
            errors++;
            $display("FAIL reset_release_early: got %0d expected 0", filtered_output);
        end
        @(posedge clk); #1;
        checks++;
        if (filtered_output !== 8'd99) begin
            errors++;
            $display("FAIL reset_first_update: got %0d expected 99", filtered_output);
        end
    endtask

    task automatic test_ramp();
        for (int i = 5; i <= 19; i++) begin
            @(negedge clk);
            drive(8'(i - 2), 8'(i), 8'(i - 1), 8'(i + 2), 8'(i + 1));
            #1;
            // new inputs must not show before the edge
            if (i > 5) begin
                checks++;
                if (filtered_output !== 8'(i - 1)) begin
                    errors++;
                    $display("FAIL ramp_latency i=%0d: got %0d expected %0d", i, filtered_output, i - 1);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (filtered_output !== 8'(i)) begin
                errors++;
                $display("FAIL ramp i=%0d: got %0d expected %0d", i, filtered_output, i);
            end
        end
    endtask

    task automatic test_duplicates();
        logic [7:0] vec [3][5];
        logic [7:0] exp_v [3];
        vec[0] = '{8'd9, 8'd9, 8'd1, 8'd200, 8'd9};        exp_v[0] = 8'd9;
        vec[1] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};     exp_v[1] = 8'hAA;
        vec[2] = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd128};    exp_v[2] = 8'd128;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(vec[k][0], vec[k][1], vec[k][2], vec[k][3], vec[k][4]);
            @(posedge clk); #1;
            checks++;
            if (filtered_output !== exp_v[k]) begin
                errors++;
                $display("FAIL duplicates #%0d: got %0d expected %0d", k, filtered_output, exp_v[k]);
            end
        end
    endtask

    task automatic test_unsigned();
        @(negedge clk);
        drive(8'h80, 8'h7F, 8'hFF, 8'h00, 8'h81);
        @(posedge clk); #1;
        checks++;
        if (filtered_output !== 8'h80) begin
            errors++;
            $display("FAIL unsigned_order: got %0h expected 80", filtered_output);
        end
    endtask

    task automatic test_impulse();
        logic [7:0] v [5];
        logic [7:0] spike [2];
        spike[0] = 8'd255;
        spike[1] = 8'd0;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 5; p++) begin
                for (int k = 0; k < 5; k++) v[k] = 8'd50;
                v[p] = spike[s];
                @(negedge clk);
                drive(v[0], v[1], v[2], v[3], v[4]);
                @(posedge clk); #1;
                checks++;
                if (filtered_output !== 8'd50) begin
                    errors++;
                    $display("FAIL impulse spike=%0d tap=%0d: got %0d expected 50", spike[s], p, filtered_output);
                end
            end
        end
    endtask

    task automatic test_permutations();
        int perm_count = 0;
        for (int a = 1; a <= 5; a++)
        for (int b = 1; b <= 5; b++)
        for (int c = 1; c <= 5; c++)
        for (int d = 1; d <= 5; d++)
        for (int e = 1; e <= 5; e++) begin
            if (a != b && a != c && a != d && a != e && b != c && b != d && b != e
                && c != d && c != e && d != e) begin
                perm_count++;
                @(negedge clk);
                drive(8'(a), 8'(b), 8'(c), 8'(d), 8'(e));
                @(posedge clk); #1;
                checks++;
                if (filtered_output !== 8'd3) begin
                    errors++;
                    $display("FAIL perm {%0d,%0d,%0d,%0d,%0d}: got %0d expected 3", a, b, c, d, e, filtered_output);
                end
            end
        end
        checks++;
        if (perm_count != 120) begin
            errors++;
            $display("FAIL perm_count: got %0d expected 120", perm_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] r [5];
        logic [7:0] e;
        int shown = 0;
        for (int n = 0; n < 10000; n++) begin
            // narrow ranges every few vectors to force ties
            for (int k = 0; k < 5; k++)
                r[k] = (n % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            @(negedge clk);
            drive(r[0], r[1], r[2], r[3], r[4]);
            exp_q.push_back(ref_median(r[0], r[1], r[2], r[3], r[4]));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (filtered_output !== e) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random #%0d {%0d,%0d,%0d,%0d,%0d}: got %0d expected %0d",
                             n, r[0], r[1], r[2], r[3], r[4], filtered_output, e);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        drive(8'd10, 8'd40, 8'd30, 8'd20, 8'd50);
        @(posedge clk); #1;
        checks++;
        if (filtered_output !== 8'd30) begin
            errors++;
            $display("FAIL mid_reset_pre: got %0d expected 30", filtered_output);
        end
        #20;
        rst_n = 1'b0;
        #1;
        checks++;
        if (filtered_output !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_async: got %0d expected 0", filtered_output);
        end
        @(negedge clk);
        drive(8'd7, 8'd70, 8'd77, 8'd100, 8'd1);
        rst_n = 1'b1;
        #1;
        checks++;
        if (filtered_output !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_hold: got %0d expected 0", filtered_output);
        end
        @(posedge clk); #1;
        checks++;
        if (filtered_output !== 8'd70) begin
            errors++;
            $display("FAIL mid_reset_resume: got %0d expected 70", filtered_output);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_ramp();
        test_duplicates();
        test_unsigned();
        test_impulse();
        test_permutations();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
